// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode/register/immediate field bundles into 16-bit
// instruction words and streams them into instruction memory from address 0.
// Optional build macro: INSTR_ENC_RANGE_CHECK_EN -- when defined, bundles whose
// immediate does not fit the instruction's field are rejected and counted;
// when undefined, immediates are silently truncated to the field width.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting bundles, one word written per accepted bundle
// DONE   | program complete (last bundle or memory full), waiting for start
module instr_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [ADDR_W:0]     wc_nxt;
    logic                err_nxt;
    logic [7:0]          ec_nxt;
    logic                we_q, we_nxt;
    logic [ADDR_W-1:0]   waddr_nxt;
    logic [15:0]         wdata_nxt;
    logic [15:0]         enc_word;
    logic                imm_ok;
    logic                full;

    // Pack the field bundle according to the opcode's instruction format.
    always_comb begin
        enc_word = {in_opcode, in_rd, in_rs, in_rt};
        case (in_opcode)
            4'h1, 4'h7, 4'h8:        enc_word = {in_opcode, in_rd, in_rs, in_imm[3:0]};
            4'h6:                    enc_word = {in_opcode, in_rd, in_imm[7:0]};
            4'h9, 4'hA, 4'hB, 4'hC:  enc_word = {in_opcode, in_imm[11:0]};
            4'hF:                    enc_word = {in_opcode, 4'h0, in_rs, in_rt};
            default:                 enc_word = {in_opcode, in_rd, in_rs, in_rt};
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // A signed value fits an N-bit field when every bit above bit N-2 matches the sign.
    always_comb begin
        imm_ok = 1'b1;
        case (in_opcode)
            4'h1, 4'h7, 4'h8:        imm_ok = (&in_imm[15:3])  | ~(|in_imm[15:3]);
            4'h6:                    imm_ok = (&in_imm[15:7])  | ~(|in_imm[15:7]);
            4'h9, 4'hA, 4'hB, 4'hC:  imm_ok = (&in_imm[15:11]) | ~(|in_imm[15:11]);
            default:                 imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
    // The top immediate bits only matter to the range check.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[15:12];
`endif

    // Next-state, address/count bookkeeping and write-port update.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        wc_nxt    = word_count;
        err_nxt   = err;
        ec_nxt    = err_count;
        we_nxt    = 1'b0;
        waddr_nxt = imem_addr;
        wdata_nxt = imem_wdata;
        full      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    addr_nxt  = '0;
                    wc_nxt    = '0;
                    err_nxt   = 1'b0;
                    ec_nxt    = 8'd0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (imm_ok) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = addr;
                        wdata_nxt = enc_word;
                        wc_nxt    = word_count + 1'b1;
                        // Hold the pointer on the last word so it never wraps.
                        if (addr == LAST_ADDR) full = 1'b1;
                        else                   addr_nxt = addr + 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                        if (err_count != 8'hFF) ec_nxt = err_count + 8'd1;
                    end
                    if (in_last || full) state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_count  <= 8'd0;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'h0000;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            word_count <= wc_nxt;
            err        <= err_nxt;
            err_count  <= ec_nxt;
            we_q       <= we_nxt;
            imem_addr  <= waddr_nxt;
            imem_wdata <= wdata_nxt;
        end
    end

    // A reset arriving while a write is pending suppresses the strobe at once.
    assign imem_we  = we_q & ~rst;
    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: constant vectors and hand sequences, plus random
// traffic compared against a cycle-level reference model.
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_last;
    logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
    logic [15:0] in_imm;
    logic        in_ready, imem_we, busy, done, err;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [7:0]  err_count;
    logic [8:0]  word_count;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .err_count(err_count), .word_count(word_count)
    );

    logic        s_rst, s_start, s_valid, s_last, s_ready, s_we, s_busy, s_done, s_err;
    logic [3:0]  s_rt;
    logic [1:0]  s_addr;
    logic [15:0] s_wdata;
    logic [7:0]  s_ec;
    logic [2:0]  s_wc;

    instr_encoder #(.DEPTH(4)) dut_small (
        .clk(clk), .rst(s_rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_opcode(4'h0), .in_rd(4'h1), .in_rs(4'h2), .in_rt(s_rt),
        .in_imm(16'h0000), .in_last(s_last), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .busy(s_busy), .done(s_done), .err(s_err),
        .err_count(s_ec), .word_count(s_wc)
    );

    int checks = 0;
    int failures = 0;

    // reference model: 0 idle, 1 load, 2 done
    int m_state, m_addr, m_wc, m_err, m_ec, m_we, m_waddr, m_wdata;

    function automatic logic [15:0] ref_word(int op, int rd, int rs, int rt, int imm);
        if (op == 1 || op == 7 || op == 8) return 16'(op*4096 + rd*256 + rs*16 + (imm & 15));
        if (op == 6)                       return 16'(op*4096 + rd*256 + (imm & 255));
        if (op >= 9 && op <= 12)           return 16'(op*4096 + (imm & 4095));
        if (op == 15)                      return 16'(61440 + rs*16 + rt);
        return 16'(op*4096 + rd*256 + rs*16 + rt);
    endfunction

    function automatic bit ref_in_range(int op, int imm);
        if (op == 1 || op == 7 || op == 8) return imm >= -8 && imm <= 7;
        if (op == 6)                       return imm >= -128 && imm <= 127;
        if (op >= 9 && op <= 12)           return imm >= -2048 && imm <= 2047;
        return 1'b1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = 0; m_addr = 0; m_wc = 0; m_err = 0; m_ec = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1; m_addr = 0; m_wc = 0; m_err = 0; m_ec = 0;
                end
            end else if (in_valid) begin
                int imm;
                bit full;
                imm  = int'($signed(in_imm));
                full = 1'b0;
                if (!CHK || ref_in_range(int'(in_opcode), imm)) begin
                    m_we = 1;
                    m_waddr = m_addr;
                    m_wdata = int'(ref_word(int'(in_opcode), int'(in_rd), int'(in_rs), int'(in_rt), imm));
                    m_wc++;
                    if (m_addr == DEPTH - 1) full = 1'b1;
                    else m_addr++;
                end else begin
                    m_err = 1;
                    if (m_ec < 255) m_ec++;
                end
                if (in_last || full) m_state = 2;
            end
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".we"},    int'(imem_we),    (m_we != 0 && !rst) ? 1 : 0);
        chk({tag, ".addr"},  int'(imem_addr),  m_waddr);
        chk({tag, ".wdata"}, int'(imem_wdata), m_wdata);
        chk({tag, ".ready"}, int'(in_ready),   (m_state == 1) ? 1 : 0);
        chk({tag, ".busy"},  int'(busy),       (m_state == 1) ? 1 : 0);
        chk({tag, ".done"},  int'(done),       (m_state == 2) ? 1 : 0);
        chk({tag, ".err"},   int'(err),        m_err);
        chk({tag, ".ecnt"},  int'(err_count),  m_ec);
        chk({tag, ".wcnt"},  int'(word_count), m_wc);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic bundle(int op, int rd, int rs, int rt, int imm, bit last);
        in_valid  = 1'b1;
        in_opcode = 4'(op); in_rd = 4'(rd); in_rs = 4'(rs); in_rt = 4'(rt);
        in_imm    = 16'(imm);
        in_last   = last;
    endtask

    typedef struct {
        logic [3:0]  op, rd, rs, rt;
        logic [15:0] imm;
        logic [15:0] word;
        bit          bad;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'h0, 4'h1, 4'h2, 4'h3, 16'h0000, 16'h0123, 1'b0};
        tbl[1]  = '{4'h2, 4'h4, 4'h5, 4'h6, 16'h0000, 16'h2456, 1'b0};
        tbl[2]  = '{4'hD, 4'h7, 4'h8, 4'h9, 16'h0000, 16'hD789, 1'b0};
        tbl[3]  = '{4'hE, 4'hA, 4'hB, 4'hC, 16'h0000, 16'hEABC, 1'b0};
        tbl[4]  = '{4'h1, 4'h3, 4'h4, 4'h0, 16'hFFF8, 16'h1348, 1'b0};
        tbl[5]  = '{4'h7, 4'h1, 4'h1, 4'h0, 16'h0007, 16'h7117, 1'b0};
        tbl[6]  = '{4'h8, 4'h2, 4'h3, 4'h0, 16'hFFF7, 16'h8237, 1'b1};
        tbl[7]  = '{4'h6, 4'h9, 4'h0, 4'h0, 16'hFF80, 16'h6980, 1'b0};
        tbl[8]  = '{4'h6, 4'h9, 4'h0, 4'h0, 16'h0080, 16'h6980, 1'b1};
        tbl[9]  = '{4'h9, 4'h0, 4'h0, 4'h0, 16'h07FF, 16'h97FF, 1'b0};
        tbl[10] = '{4'hC, 4'h0, 4'h0, 4'h0, 16'hF800, 16'hC800, 1'b0};
        tbl[11] = '{4'hB, 4'h0, 4'h0, 4'h0, 16'h0800, 16'hB800, 1'b1};
        tbl[12] = '{4'hF, 4'h9, 4'h4, 4'h5, 16'h0000, 16'hF045, 1'b0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 4'h0; in_rd = 4'h0; in_rs = 4'h0; in_rt = 4'h0; in_imm = 16'h0000;
        s_rst = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_rt = 4'h0;

        // reset state
        tick("rst0"); tick("rst1");
        chk("reset.ready", int'(in_ready), 0);
        chk("reset.we", int'(imem_we), 0);
        chk("reset.wcnt", int'(word_count), 0);
        rst = 1'b0;

        // single ADD
        start = 1'b1; tick("start");
        start = 1'b0; bundle(0, 1, 2, 3, 0, 1'b0); tick("add");
        chk("add.we", int'(imem_we), 1);
        chk("add.addr", int'(imem_addr), 0);
        chk("add.wdata", int'(imem_wdata), 16'h0123);
        chk("add.wcnt", int'(word_count), 1);

        // CMP ignores rd
        bundle(15, 9, 4, 5, 0, 1'b0); tick("cmp");
        chk("cmp.wdata", int'(imem_wdata), 16'hF045);
        chk("cmp.addr", int'(imem_addr), 1);

        // ADDI imm=8: out of range for a 4-bit field
        bundle(1, 1, 2, 0, 8, 1'b0); tick("addi8");
        chk("addi8.we", int'(imem_we), CHK ? 0 : 1);
        chk("addi8.wdata", int'(imem_wdata), CHK ? 16'hF045 : 16'h1128);
        chk("addi8.err", int'(err), CHK ? 1 : 0);
        chk("addi8.ecnt", int'(err_count), CHK ? 1 : 0);
        chk("addi8.wcnt", int'(word_count), CHK ? 2 : 3);

        // reset the cycle after an accepted bundle
        bundle(0, 3, 3, 3, 0, 1'b0); tick("pre_rst");
        in_valid = 1'b0; rst = 1'b1; #1;
        chk("rst_mid.we_now", int'(imem_we), 0);
        tick("rst_mid");
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.wdata", int'(imem_wdata), 0);
        chk("rst_mid.addr", int'(imem_addr), 0);
        chk("rst_mid.wcnt", int'(word_count), 0);
        rst = 1'b0; tick("rst_rel");
        chk("rst_rel.we", int'(imem_we), 0);

        // three-word program ending on in_last
        start = 1'b1; tick("p_start"); start = 1'b0;
        bundle(1, 1, 2, 0, -1, 1'b0); tick("p0");
        chk("p0.wdata", int'(imem_wdata), 16'h112F); chk("p0.addr", int'(imem_addr), 0);
        bundle(6, 5, 0, 0, 127, 1'b0); tick("p1");
        chk("p1.wdata", int'(imem_wdata), 16'h657F); chk("p1.addr", int'(imem_addr), 1);
        bundle(10, 0, 0, 0, -2, 1'b1); tick("p2");
        chk("p2.we", int'(imem_we), 1);
        chk("p2.wdata", int'(imem_wdata), 16'hAFFE); chk("p2.addr", int'(imem_addr), 2);
        chk("p2.done", int'(done), 1); chk("p2.ready", int'(in_ready), 0);
        in_valid = 1'b0; in_last = 1'b0; tick("p_after");
        chk("p_after.we", int'(imem_we), 0);

        // vector table, back-to-back
        start = 1'b1; tick("t_start"); start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bundle(int'(tbl[i].op), int'(tbl[i].rd), int'(tbl[i].rs), int'(tbl[i].rt),
                   int'($signed(tbl[i].imm)), 1'b0);
            tick("tbl");
            chk($sformatf("tbl%0d.we", i), int'(imem_we), (CHK && tbl[i].bad) ? 0 : 1);
            if (!(CHK && tbl[i].bad))
                chk($sformatf("tbl%0d.wdata", i), int'(imem_wdata), int'(tbl[i].word));
        end
        in_valid = 1'b0;

        // DEPTH=4: continuous valid, no in_last, fills and stops
        s_rst = 1'b0; s_start = 1'b1; tick("s_start"); s_start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_rt = 4'(i);
            tick("s_fill");
            chk($sformatf("small%0d.we", i), int'(s_we), (i < 4) ? 1 : 0);
            if (i < 4) begin
                chk($sformatf("small%0d.addr", i), int'(s_addr), i);
                chk($sformatf("small%0d.wdata", i), int'(s_wdata), 16'h0120 + i);
            end
            chk($sformatf("small%0d.ready", i), int'(s_ready), (i < 3) ? 1 : 0);
            chk($sformatf("small%0d.wcnt", i), int'(s_wc), (i < 4) ? i + 1 : 4);
        end
        chk("small.done", int'(s_done), 1);
        chk("small.addr_hold", int'(s_addr), 3);
        s_valid = 1'b0;

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int tmp;
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 15) == 0);
            tmp   = int'($urandom_range(0, 20)) - 10;
            bundle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 1) ? tmp : int'($urandom_range(0, 65535)),
                   $urandom_range(0, 40) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
